// File: rtl/pulse_ce_shift_multi.sv
// Multi-channel pulse rate converter: queues 1-clk pulses per channel and re-issues each
// as one slow period (slow_ce to slow_ce) of pulse_out, plus a 1-clk pulse_stb.
module pulse_ce_lane #(
    parameter int CNT_W = 3,
    parameter int MODE  = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic slow_ce,
    input  logic pulse_in,
    input  logic clr_ovf,
    output logic pulse_out,
    output logic pulse_stb,
    output logic pending,
    output logic overflow
);
    // Merge mode caps the queue at one so extra pulses collapse silently.
    localparam logic [CNT_W-1:0] MAX_PEND = (MODE != 0) ? CNT_W'(1) : {CNT_W{1'b1}};

    logic [CNT_W-1:0] pend;
    logic             busy;
    logic             inc;
    logic             dec;
    logic             at_max;
    logic             ovf_set;

    assign busy    = (pend != '0);
    assign inc     = pulse_in;
    assign dec     = slow_ce & busy;
    assign at_max  = (pend == MAX_PEND);
    assign ovf_set = (MODE == 0) && inc && !dec && at_max;
    assign pending = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= '0;
            pulse_out <= 1'b0;
            pulse_stb <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (inc && !dec && !at_max)
                pend <= pend + CNT_W'(1);
            else if (dec && !inc)
                pend <= pend - CNT_W'(1);

            // Issue decision looks at pend before this cycle's update.
            if (slow_ce)
                pulse_out <= busy;
            pulse_stb <= slow_ce & busy;

            if (ovf_set)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end
endmodule

module pulse_ce_shift_multi #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 3,
    parameter int MODE  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            slow_ce,
    input  logic [N_CH-1:0] pulse_in,
    input  logic            clr_ovf,
    output logic [N_CH-1:0] pulse_out,
    output logic [N_CH-1:0] pulse_stb,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] overflow
);
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        pulse_ce_lane #(
            .CNT_W (CNT_W),
            .MODE  (MODE)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .slow_ce   (slow_ce),
            .pulse_in  (pulse_in[c]),
            .clr_ovf   (clr_ovf),
            .pulse_out (pulse_out[c]),
            .pulse_stb (pulse_stb[c]),
            .pending   (pending[c]),
            .overflow  (overflow[c])
        );
    end
endmodule
